// File: rtl/alu_pipe_acc.sv
// rtl/alu_pipe_acc.sv - two-stage valid/ready ALU with accumulator, status flags and optional signed saturation (ALU_SAT_EN)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand beat handshake
//   opcode, acc_sel, acc_wr  operation select, A = acc when acc_sel, write result to acc when acc_wr
//   in0, in1                 operand A / operand B (shift amount = in1[SHW-1:0])
//   out_valid/out_ready      result handshake
//   out, flags               result and {carry, overflow, negative, zero}
//   acc                      current accumulator value
// Build option: ALU_SAT_EN makes ADD/SUB saturate as signed values.

module alu_pipe_acc #(
    parameter int N   = 8,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   opcode,
    input  logic         acc_sel,
    input  logic         acc_wr,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [3:0]   flags,
    output logic [N-1:0] acc
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // S1: captured operands
    logic         s1_valid;
    logic [2:0]   s1_op;
    logic         s1_acc_sel;
    logic         s1_acc_wr;
    logic [N-1:0] s1_in0;
    logic [N-1:0] s1_in1;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Compute on the S1 -> S2 transfer
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [SHW-1:0] amt;
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [N:0]     shl_wide;
    logic [N:0]     shr_wide;
    logic [N-1:0]   res;
    logic           res_c;
    logic           res_v;

    // Operand A reads the acc register, so a beat directly behind an
    // acc_wr beat sees the value written at the same edge it entered S1.
    assign op_a = s1_acc_sel ? acc : s1_in0;
    assign op_b = s1_in1;
    assign amt  = op_b[SHW-1:0];

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};
    // Extra guard bit catches the last bit shifted out; it stays 0 for amt=0.
    assign shl_wide = {1'b0, op_a} << amt;
    assign shr_wide = {op_a, 1'b0} >> amt;

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res   = sum[N-1:0];
                res_c = sum[N];
                res_v = (op_a[N-1] == op_b[N-1]) && (sum[N-1] != op_a[N-1]);
            end
            OP_SUB: begin
                res   = diff[N-1:0];
                res_c = diff[N];
                res_v = (op_a[N-1] != op_b[N-1]) && (diff[N-1] != op_a[N-1]);
            end
            OP_OR:    res = op_a | op_b;
            OP_XOR:   res = op_a ^ op_b;
            OP_AND:   res = op_a & op_b;
            OP_SHL: begin
                res   = shl_wide[N-1:0];
                res_c = shl_wide[N];
            end
            OP_SHR: begin
                res   = shr_wide[N:1];
                res_c = shr_wide[0];
            end
            OP_PASSB: res = op_b;
            default:  res = '0;
        endcase
`ifdef ALU_SAT_EN
        // Overflow only happens when the true result has A's sign, so A's
        // sign picks the clamp direction.
        if (res_v) begin
            res = op_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_acc_sel <= 1'b0;
            s1_acc_wr  <= 1'b0;
            s1_in0     <= '0;
            s1_in1     <= '0;
            out_valid  <= 1'b0;
            out        <= '0;
            flags      <= '0;
            acc        <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out   <= res;
                    flags <= {res_c, res_v, res[N-1], (res == '0)};
                    if (s1_acc_wr) begin
                        acc <= res;
                    end
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op      <= opcode;
                    s1_acc_sel <= acc_sel;
                    s1_acc_wr  <= acc_wr;
                    s1_in0     <= in0;
                    s1_in1     <= in1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_acc.sv
// tb/tb_alu_pipe_acc.sv - directed self-checking bench for alu_pipe_acc (N=8)

module tb_alu_pipe_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic       acc_sel;
    logic       acc_wr;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flags;
    logic [7:0] acc;

    int asserts = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [7:0] got_out[$];
    logic [3:0] got_flags[$];
    int         got_cyc[$];

    alu_pipe_acc #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .acc_sel(acc_sel), .acc_wr(acc_wr),
        .in0(in0), .in1(in1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags), .acc(acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_out.push_back(out);
            got_flags.push_back(flags);
            got_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        got_out.delete();
        got_flags.delete();
        got_cyc.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [2:0] op, input logic sel, input logic wr,
                        input logic [7:0] a, input logic [7:0] b);
        int t;
        t = 0;
        opcode = op; acc_sel = sel; acc_wr = wr; in0 = a; in1 = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            asserts++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        asserts++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        asserts++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out); end
        asserts++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
        asserts++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h want 00", acc); end
        asserts++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_add_latency();
        out_ready = 1'b1;
        opcode = 3'b000; acc_sel = 1'b0; acc_wr = 1'b0; in0 = 8'hF0; in1 = 8'h20;
        in_valid = 1'b1;
        @(negedge clk);
        asserts++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        asserts++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %0b want 0", out_valid); end
        @(posedge clk); #1;
        asserts++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", out_valid); end
        asserts++; if (out !== 8'h10) begin errors++; $display("FAIL add_out: got %h want 10", out); end
        asserts++; if (flags !== 4'b1000) begin errors++; $display("FAIL add_flags: got %b want 1000", flags); end
        idle(2);
    endtask

    task automatic test_sub_overflow();
        logic [7:0] exp_out;
        logic [3:0] exp_flags;
`ifdef ALU_SAT_EN
        exp_out = 8'h7F; exp_flags = 4'b1100;
`else
        exp_out = 8'hFF; exp_flags = 4'b1110;
`endif
        clear_q();
        send(3'b010, 1'b0, 1'b0, 8'h7F, 8'h80);
        idle(3);
        asserts++; if (got_out.size() !== 1) begin errors++; $display("FAIL sub_count: got %0d want 1", got_out.size()); end
        else begin
            asserts++; if (got_out[0] !== exp_out) begin errors++; $display("FAIL sub_out: got %h want %h", got_out[0], exp_out); end
            asserts++; if (got_flags[0] !== exp_flags) begin errors++; $display("FAIL sub_flags: got %b want %b", got_flags[0], exp_flags); end
        end
    endtask

    task automatic test_acc_chain();
        logic [7:0] exp[4];
        exp[0] = 8'd5; exp[1] = 8'd8; exp[2] = 8'd11; exp[3] = 8'd14;
        clear_q();
        send(3'b000, 1'b0, 1'b1, 8'd5, 8'd0);
        send(3'b000, 1'b1, 1'b1, 8'hEE, 8'd3);
        send(3'b000, 1'b1, 1'b1, 8'hEE, 8'd3);
        send(3'b000, 1'b1, 1'b1, 8'hEE, 8'd3);
        idle(3);
        asserts++; if (got_out.size() !== 4) begin errors++; $display("FAIL chain_count: got %0d want 4", got_out.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                asserts++; if (got_out[i] !== exp[i]) begin errors++; $display("FAIL chain_out%0d: got %0d want %0d", i, got_out[i], exp[i]); end
                asserts++; if (got_cyc[i] !== got_cyc[0] + i) begin errors++; $display("FAIL chain_bubble%0d: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i); end
            end
        end
        asserts++; if (acc !== 8'd14) begin errors++; $display("FAIL chain_acc: got %0d want 14", acc); end
    endtask

    task automatic test_backpressure();
        logic [2:0] ops[4];
        logic [7:0] as[4];
        logic [7:0] bs[4];
        logic [7:0] exp[4];
        logic [7:0] held_out;
        logic [3:0] held_flags;
        int idx, drop_idx, stall_seen, stable_bad;
        logic take;
        ops[0] = 3'b001; as[0] = 8'h0F; bs[0] = 8'h30; exp[0] = 8'h3F;
        ops[1] = 3'b011; as[1] = 8'hFF; bs[1] = 8'h0F; exp[1] = 8'hF0;
        ops[2] = 3'b100; as[2] = 8'hF0; bs[2] = 8'h3C; exp[2] = 8'h30;
        ops[3] = 3'b111; as[3] = 8'h00; bs[3] = 8'h5A; exp[3] = 8'h5A;
        clear_q();
        idx = 0; drop_idx = -1; stall_seen = 0; stable_bad = 0;
        held_out = '0; held_flags = '0;
        for (int c = 0; c < 40 && got_out.size() < 4; c++) begin
            out_ready = (c >= 5);
            if (idx < 4) begin
                opcode = ops[idx]; acc_sel = 1'b0; acc_wr = 1'b0;
                in0 = as[idx]; in1 = bs[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!out_ready && out_valid) begin
                if (stall_seen == 0) begin
                    held_out = out; held_flags = flags;
                end else if (out !== held_out || flags !== held_flags) begin
                    stable_bad++;
                end
                stall_seen++;
            end
            if (!in_ready && drop_idx < 0) drop_idx = idx;
            take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        asserts++; if (drop_idx !== 2) begin errors++; $display("FAIL bp_drop_after: got %0d want 2", drop_idx); end
        asserts++; if (stall_seen < 3) begin errors++; $display("FAIL bp_stall_seen: got %0d want >=3", stall_seen); end
        asserts++; if (stable_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stable_bad); end
        asserts++; if (got_out.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got_out.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                asserts++; if (got_out[i] !== exp[i]) begin errors++; $display("FAIL bp_out%0d: got %h want %h", i, got_out[i], exp[i]); end
            end
        end
    endtask

    task automatic test_shift();
        clear_q();
        out_ready = 1'b1;
        send(3'b101, 1'b0, 1'b0, 8'h81, 8'h01);
        send(3'b110, 1'b0, 1'b0, 8'h01, 8'h01);
        idle(3);
        asserts++; if (got_out.size() !== 2) begin errors++; $display("FAIL shift_count: got %0d want 2", got_out.size()); end
        else begin
            asserts++; if (got_out[0] !== 8'h02) begin errors++; $display("FAIL shl_out: got %h want 02", got_out[0]); end
            asserts++; if (got_flags[0] !== 4'b1000) begin errors++; $display("FAIL shl_flags: got %b want 1000", got_flags[0]); end
            asserts++; if (got_out[1] !== 8'h00) begin errors++; $display("FAIL shr_out: got %h want 00", got_out[1]); end
            asserts++; if (got_flags[1] !== 4'b1001) begin errors++; $display("FAIL shr_flags: got %b want 1001", got_flags[1]); end
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        out_ready = 1'b0;
        send(3'b000, 1'b0, 1'b1, 8'h11, 8'h22);
        send(3'b000, 1'b0, 1'b1, 8'h01, 8'h01);
        asserts++; if (acc !== 8'h33) begin errors++; $display("FAIL mid_acc_before: got %h want 33", acc); end
        asserts++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %0b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        asserts++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
        asserts++; if (out !== 8'h00) begin errors++; $display("FAIL mid_out: got %h want 00", out); end
        asserts++; if (acc !== 8'h00) begin errors++; $display("FAIL mid_acc: got %h want 00", acc); end
        asserts++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b want 1", in_ready); end
        out_ready = 1'b1;
        idle(6);
        asserts++; if (got_out.size() !== 0) begin errors++; $display("FAIL mid_stale: got %0d results want 0", got_out.size()); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; acc_sel = 1'b0; acc_wr = 1'b0; in0 = '0; in1 = '0;
        @(posedge clk); #1;
        test_reset();
        test_add_latency();
        test_sub_overflow();
        test_acc_chain();
        test_backpressure();
        test_shift();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

endmodule
